wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//   Single-clock Wishbone classic-cycle initiator. Accepts one command at a time on a valid/ready
//   command port, runs it as a Wishbone cycle, and returns data plus status on a valid/ready
//   response port. Retries on RTY up to a limit and aborts on timeout. Drives the master-side
//   inputs of Wishbone bridges, interconnects and slaves.
// PARAMETERS
//   DATA_WIDTH   32               data bus width in bits (8, 16, 32 or 64)
//   ADDR_WIDTH   32               address bus width in bits
//   SELECT_WIDTH DATA_WIDTH/8     byte select width
//   RETRY_LIMIT  4                re-issues allowed after RTY (0 = no retries), 0..255
//   TIMEOUT      1024             cycles per attempt without termination before abort (0 = disabled)
// PORTS
//   clk          in   1             clock; all logic on posedge
//   rst_n        in   1             asynchronous reset, active-low
//   cmd_addr     in   ADDR_WIDTH    command address
//   cmd_data     in   DATA_WIDTH    write data
//   cmd_sel      in   SELECT_WIDTH  byte selects
//   cmd_we       in   1             1 = write, 0 = read
//   cmd_valid    in   1             command valid
//   cmd_ready    out  1             command accepted when valid & ready
//   rsp_data     out  DATA_WIDTH    read data (0 for writes and failures)
//   rsp_status   out  2             00 OK(ack), 01 ERR, 10 RTY limit exhausted, 11 TIMEOUT
//   rsp_valid    out  1             response valid, held until rsp_ready
//   rsp_ready    in   1             response consumer ready
//   wbm_adr_o    out  ADDR_WIDTH    ADR_O
//   wbm_dat_i    in   DATA_WIDTH    DAT_I
//   wbm_dat_o    out  DATA_WIDTH    DAT_O
//   wbm_we_o     out  1             WE_O
//   wbm_sel_o    out  SELECT_WIDTH  SEL_O
//   wbm_stb_o    out  1             STB_O
//   wbm_ack_i    in   1             ACK_I
//   wbm_err_i    in   1             ERR_I
//   wbm_rty_i    in   1             RTY_I
//   wbm_cyc_o    out  1             CYC_O
//   busy         out  1             high in every state except IDLE
// BEHAVIOUR
//   - All outputs registered. While rst_n low: every output 0 (cmd_ready 0), state IDLE,
//     counters 0. cmd_ready rises on the first clk edge after rst_n deasserts.
//   - States: IDLE, BUS, BACKOFF, RESP.
//   - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the command, cmd_ready->0, retry
//     count->0, go BUS. cyc/stb/adr/sel/we assert on the next edge (1-cycle latency).
//     wbm_dat_o = cmd_data for writes, 0 for reads.
//   - BUS: cyc=stb=1; adr/dat_o/sel/we held stable. Termination is sampled each cycle.
//     Priority when several are high: err > rty > ack.
//       ack: cyc/stb/we->0 on the next edge; rsp_data = wbm_dat_i (reads) or 0 (writes);
//            status 00; rsp_valid=1 on that same edge; go RESP.
//       err: as ack, but rsp_data=0 and status 01.
//       rty: if retry count < RETRY_LIMIT: count++, cyc/stb->0 for exactly 1 cycle (BACKOFF),
//            then reassert with identical adr/dat/sel/we and return to BUS.
//            Otherwise: status 10, rsp_data=0, go RESP.
//       none: the per-attempt timeout counter increments. When it reaches TIMEOUT (TIMEOUT != 0),
//            cyc/stb->0, status 11, rsp_data=0, go RESP. The counter clears on entry to BUS.
//   - Terminations seen while cyc=0 (BACKOFF, RESP, IDLE) are ignored.
//   - RESP: rsp_valid=1 and rsp_data/rsp_status held stable until rsp_valid&rsp_ready; then
//     rsp_valid->0, cmd_ready->1 (IDLE) on the same edge. Minimum command-to-command spacing
//     is 3 cycles (accept, 1 bus cycle with immediate ack, response taken in the cycle it appears).
//   - rst_n asserted mid-operation: cyc/stb drop asynchronously, the in-flight command is
//     discarded, and no response is produced.
//   - Timeout counter width clog2(TIMEOUT+1); retry counter 8 bits. Neither wraps; both saturate
//     at their terminal value.
// TESTING
//   1 read: cmd addr=0x100, we=0, sel=0xF; slave acks 2 cycles after stb with dat=0xDEADBEEF ->
//     one cyc pulse 2 cycles long; rsp_data=0xDEADBEEF, status=00; cmd_ready back after rsp taken.
//   2 write: addr=0x4, data=0x12345678, sel=0x3; immediate ack -> dat_o=0x12345678, we=1 during
//     cyc; rsp_data=0, status=00.
//   3 retry: RETRY_LIMIT=2; slave rty twice, then ack -> 3 cyc pulses, each separated by exactly 1
//     low cycle, adr stable; status=00. Slave rty always -> 3 pulses, then status=10.
//   4 err and priority: ack+err+rty asserted in the same cycle -> status=01, no retry, rsp_data=0.
//   5 timeout: TIMEOUT=16, slave silent -> cyc high for 16 cycles then low; status=11. TIMEOUT=0
//     with a silent slave -> cyc remains high for 10000 cycles.
//   6 backpressure/reset: rsp_ready held 0 for 20 cycles -> rsp fields stable, cmd_ready=0.
//     rst_n pulsed low during BUS -> cyc=0 immediately, no rsp_valid, cmd_ready=1 one edge after release.

Source files
------------

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-command Wishbone classic-cycle initiator.
// Takes one command on a valid/ready port, runs it as a Wishbone cycle,
// retries on RTY up to RETRY_LIMIT, aborts after TIMEOUT silent cycles and
// returns data plus status on a valid/ready response port.
module wb_cmd_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int RETRY_LIMIT  = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  input  logic                    cmd_we,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i,
  output logic                    wbm_cyc_o,
  output logic                    busy
);

  // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  // The abort fires on the cycle the counter would step onto TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [7:0]       RETRY_MAX = 8'(RETRY_LIMIT);

  localparam logic [DATA_WIDTH-1:0]   DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]   ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [SELECT_WIDTH-1:0] SEL_ZERO  = {SELECT_WIDTH{1'b0}};

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_BACKOFF = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    cmd_ready_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;
  logic [1:0]              rsp_status_r;
  logic                    rsp_valid_r;
  logic [ADDR_WIDTH-1:0]   adr_r;
  logic [DATA_WIDTH-1:0]   dat_o_r;
  logic                    we_r;
  logic [SELECT_WIDTH-1:0] sel_r;
  logic                    stb_r;
  logic                    cyc_r;
  logic                    busy_r;
  logic [7:0]              retry_cnt_r;
  logic [TMO_W-1:0]        tmo_cnt_r;

  logic                    tmo_expired_s;
  logic                    term_done_s;
  logic                    term_retry_s;
  logic [1:0]              term_status_s;
  logic [DATA_WIDTH-1:0]   term_data_s;

  assign tmo_expired_s = TMO_EN && (tmo_cnt_r == TMO_LAST);

  // Decode the bus termination for the current BUS cycle: err beats rty beats ack.
  always_comb begin
    term_done_s   = 1'b0;
    term_retry_s  = 1'b0;
    term_status_s = ST_OK;
    term_data_s   = DATA_ZERO;
    if (wbm_err_i) begin
      term_done_s   = 1'b1;
      term_status_s = ST_ERR;
    end else if (wbm_rty_i) begin
      if (retry_cnt_r < RETRY_MAX) begin
        term_retry_s = 1'b1;
      end else begin
        term_done_s   = 1'b1;
        term_status_s = ST_RTY;
      end
    end else if (wbm_ack_i) begin
      term_done_s   = 1'b1;
      term_status_s = ST_OK;
      term_data_s   = we_r ? DATA_ZERO : wbm_dat_i;
    end else if (tmo_expired_s) begin
      term_done_s   = 1'b1;
      term_status_s = ST_TMO;
    end else begin
      term_done_s   = 1'b0;
    end
  end

  // Command/bus/response state machine; every port output is a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cmd_ready_r  <= 1'b0;
      rsp_data_r   <= DATA_ZERO;
      rsp_status_r <= ST_OK;
      rsp_valid_r  <= 1'b0;
      adr_r        <= ADDR_ZERO;
      dat_o_r      <= DATA_ZERO;
      we_r         <= 1'b0;
      sel_r        <= SEL_ZERO;
      stb_r        <= 1'b0;
      cyc_r        <= 1'b0;
      busy_r       <= 1'b0;
      retry_cnt_r  <= 8'd0;
      tmo_cnt_r    <= TMO_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            adr_r       <= cmd_addr;
            dat_o_r     <= cmd_we ? cmd_data : DATA_ZERO;
            sel_r       <= cmd_sel;
            we_r        <= cmd_we;
            cyc_r       <= 1'b1;
            stb_r       <= 1'b1;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            retry_cnt_r <= 8'd0;
            tmo_cnt_r   <= TMO_ZERO;
            state_r     <= S_BUS;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        S_BUS: begin
          if (term_done_s) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            rsp_valid_r  <= 1'b1;
            rsp_status_r <= term_status_s;
            rsp_data_r   <= term_data_s;
            state_r      <= S_RESP;
          end else if (term_retry_s) begin
            // Drop the strobe for exactly one cycle before re-issuing.
            retry_cnt_r <= retry_cnt_r + 8'd1;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            state_r     <= S_BACKOFF;
          end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        S_BACKOFF: begin
          cyc_r     <= 1'b1;
          stb_r     <= 1'b1;
          tmo_cnt_r <= TMO_ZERO;
          state_r   <= S_BUS;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          cyc_r       <= 1'b0;
          stb_r       <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_status = rsp_status_r;
  assign rsp_valid  = rsp_valid_r;
  assign wbm_adr_o  = adr_r;
  assign wbm_dat_o  = dat_o_r;
  assign wbm_we_o   = we_r;
  assign wbm_sel_o  = sel_r;
  assign wbm_stb_o  = stb_r;
  assign wbm_cyc_o  = cyc_r;
  assign busy       = busy_r;

endmodule
